// File: rtl/computer_pkg.sv
// Shared definitions for the microcoded computer: opcodes, bus source codes,
// T-state names and the control word carried from decode to the output pins.
package computer_pkg;

   localparam int OPCODE_W_DEF  = 4;
   localparam int NUM_STEPS_DEF = 5;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] BUS_RAM  = 3'd0;
   localparam logic [2:0] BUS_PC   = 3'd1;
   localparam logic [2:0] BUS_IR   = 3'd2;
   localparam logic [2:0] BUS_A    = 3'd3;
   localparam logic [2:0] BUS_B    = 3'd4;
   localparam logic [2:0] BUS_ALU  = 3'd5;
   localparam logic [2:0] BUS_NONE = 3'd7;

   localparam logic [2:0] STEP_T0 = 3'd0;
   localparam logic [2:0] STEP_T1 = 3'd1;
   localparam logic [2:0] STEP_T2 = 3'd2;
   localparam logic [2:0] STEP_T3 = 3'd3;
   localparam logic [2:0] STEP_T4 = 3'd4;

   typedef struct packed {
      logic       halt;
      logic       mem;
      logic       ram;
      logic       inst_in;
      logic       reg_a;
      logic       reg_b;
      logic       sub;
      logic       disp;
      logic       inc;
      logic       prog_c;
      logic       flag;
      logic [2:0] bus_sel;
   } ctrl_t;

   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c         = '0;
      c.bus_sel = BUS_NONE;
      return c;
   endfunction

endpackage

// File: rtl/control_sequencer_step_counter.sv
// T-state counter: synchronous active-low clear, freeze (hold) and early clear
// back to T0; otherwise counts up and wraps from NUM_STEPS-1 to 0.
module step_counter
   import computer_pkg::*;
#(
   parameter int NUM_STEPS = NUM_STEPS_DEF
) (
   input  logic       clk,
   input  logic       res,
   input  logic       freeze,
   input  logic       early_clr,
   output logic [2:0] step
);

   always_ff @(posedge clk) begin
      if (!res) begin
         step <= STEP_T0;
      end else if (freeze) begin
         step <= step;
      end else if (early_clr || (step == 3'(NUM_STEPS - 1))) begin
         step <= STEP_T0;
      end else begin
         step <= step + 3'd1;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: fetch in T0-T1, opcode-dependent execute in T2-T4.
// Define CTRL_EARLY_FETCH_EN to return to T0 right after the last busy execute step.
module control_sequencer
   import computer_pkg::*;
#(
   parameter int OPCODE_W  = OPCODE_W_DEF,
   parameter int NUM_STEPS = NUM_STEPS_DEF
) (
   input  logic       clk,
   input  logic       res,
   input  logic [7:0] inst,
   input  logic       carryFlag,
   input  logic       zeroFlag,
   output logic       halt,
   output logic       mem,
   output logic       ram,
   output logic       instIn,
   output logic       regA,
   output logic       regB,
   output logic       sub,
   output logic       disp,
   output logic       inc,
   output logic       progC,
   output logic       flag,
   output logic [2:0] bus_sel,
   output logic [2:0] step
);

`ifdef CTRL_EARLY_FETCH_EN
   localparam logic EARLY_EN = 1'b1;
`else
   localparam logic EARLY_EN = 1'b0;
`endif

   logic [OPCODE_W-1:0] opcode;
   logic                halted;
   logic                set_halt;
   logic                freeze;
   logic                early_clr;
   ctrl_t               ctrl;

   assign opcode = inst[7 -: OPCODE_W];

   step_counter #(.NUM_STEPS(NUM_STEPS)) u_step (
      .clk       (clk),
      .res       (res),
      .freeze    (freeze),
      .early_clr (early_clr),
      .step      (step)
   );

   // Reset during HLT T2 wins, so halted never sets on the reset edge.
   always_ff @(posedge clk) begin
      if (!res) begin
         halted <= 1'b0;
      end else if (set_halt) begin
         halted <= 1'b1;
      end
   end

   always_comb begin
      ctrl      = ctrl_idle();
      set_halt  = 1'b0;
      freeze    = 1'b0;
      early_clr = 1'b0;
      if (!res) begin
         ctrl = ctrl_idle();
      end else if (halted) begin
         ctrl.halt = 1'b1;
         freeze    = 1'b1;
      end else begin
         case (step)
            STEP_T0: begin
               ctrl.bus_sel = BUS_PC;
               ctrl.mem     = 1'b1;
            end
            STEP_T1: begin
               ctrl.bus_sel = BUS_RAM;
               ctrl.inst_in = 1'b1;
               ctrl.inc     = 1'b1;
            end
            STEP_T2: begin
               // Operations that finish here (or do nothing) may refetch early.
               early_clr = EARLY_EN;
               case (opcode)
                  OPCODE_W'(OP_LDA), OPCODE_W'(OP_ADD),
                  OPCODE_W'(OP_SUB), OPCODE_W'(OP_STA): begin
                     ctrl.bus_sel = BUS_IR;
                     ctrl.mem     = 1'b1;
                     early_clr    = 1'b0;
                  end
                  OPCODE_W'(OP_LDI): begin
                     ctrl.bus_sel = BUS_IR;
                     ctrl.reg_a   = 1'b1;
                  end
                  OPCODE_W'(OP_JMP): begin
                     ctrl.bus_sel = BUS_IR;
                     ctrl.prog_c  = 1'b1;
                  end
                  OPCODE_W'(OP_JC): begin
                     if (carryFlag) begin
                        ctrl.bus_sel = BUS_IR;
                        ctrl.prog_c  = 1'b1;
                     end
                  end
                  OPCODE_W'(OP_JZ): begin
                     if (zeroFlag) begin
                        ctrl.bus_sel = BUS_IR;
                        ctrl.prog_c  = 1'b1;
                     end
                  end
                  OPCODE_W'(OP_OUT): begin
                     ctrl.bus_sel = BUS_A;
                     ctrl.disp    = 1'b1;
                  end
                  OPCODE_W'(OP_HLT): begin
                     ctrl.halt = 1'b1;
                     set_halt  = 1'b1;
                     freeze    = 1'b1;
                     early_clr = 1'b0;
                  end
                  default: ;
               endcase
            end
            STEP_T3: begin
               case (opcode)
                  OPCODE_W'(OP_LDA): begin
                     ctrl.bus_sel = BUS_RAM;
                     ctrl.reg_a   = 1'b1;
                     early_clr    = EARLY_EN;
                  end
                  OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
                     ctrl.bus_sel = BUS_RAM;
                     ctrl.reg_b   = 1'b1;
                     ctrl.sub     = (opcode == OPCODE_W'(OP_SUB));
                  end
                  OPCODE_W'(OP_STA): begin
                     ctrl.bus_sel = BUS_A;
                     ctrl.ram     = 1'b1;
                     early_clr    = EARLY_EN;
                  end
                  default: ;
               endcase
            end
            STEP_T4: begin
               if ((opcode == OPCODE_W'(OP_ADD)) || (opcode == OPCODE_W'(OP_SUB))) begin
                  ctrl.bus_sel = BUS_ALU;
                  ctrl.reg_a   = 1'b1;
                  ctrl.flag    = 1'b1;
                  ctrl.sub     = (opcode == OPCODE_W'(OP_SUB));
               end
            end
            default: ;
         endcase
      end
   end

   assign halt    = ctrl.halt;
   assign mem     = ctrl.mem;
   assign ram     = ctrl.ram;
   assign instIn  = ctrl.inst_in;
   assign regA    = ctrl.reg_a;
   assign regB    = ctrl.reg_b;
   assign sub     = ctrl.sub;
   assign disp    = ctrl.disp;
   assign inc     = ctrl.inc;
   assign progC   = ctrl.prog_c;
   assign flag    = ctrl.flag;
   assign bus_sel = ctrl.bus_sel;

endmodule
